// File: rtl/loader_pkg.sv
// Shared constants and state encoding for the byte-stream memory loader.
package loader_pkg;

    localparam int          MEM_DEPTH_DEF = 512;
    localparam logic [7:0]  IMEM_TAG_DEF  = 8'hA5;
    localparam logic [7:0]  DMEM_TAG_DEF  = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DAT_HI = 3'd3,
        ST_DAT_LO = 3'd4,
        ST_WRITE  = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

endpackage

// File: rtl/mem_loader.sv
// Frame-driven loader: tag byte, 16-bit word count, then big-endian words
// written one per WRITE cycle into the instruction or data memory.
module mem_loader
    import loader_pkg::*;
#(
    parameter int         MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter logic [7:0] IMEM_TAG   = IMEM_TAG_DEF,
    parameter logic [7:0] DMEM_TAG   = DMEM_TAG_DEF,
    parameter bit         AUTO_START = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] addr_ext,
    output logic [15:0] iram_in_ext,
    output logic [15:0] data_in_ext,
    output logic        mem_write_ins,
    output logic        mem_write_data_ext,
    output logic        start,
    output logic        busy,
    output logic        err
);

    state_t      state_q, state_d;
    logic [15:0] idx_q,   idx_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [7:0]  hi_q,    hi_d;
    logic [15:0] word_q,  word_d;
    logic [15:0] addr_q,  addr_d;
    logic        imem_q,  imem_d;
    logic        err_q,   err_d;

    logic        accept;
    logic [15:0] len;
    logic [15:0] idx_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            imem_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            imem_q  <= imem_d;
            err_q   <= err_d;
        end
    end

    assign in_ready = (state_q == ST_IDLE)   || (state_q == ST_LEN_HI) ||
                      (state_q == ST_LEN_LO) || (state_q == ST_DAT_HI) ||
                      (state_q == ST_DAT_LO);
    assign accept   = in_valid && in_ready;
    assign len      = {cnt_q[15:8], in_byte};
    assign idx_inc  = idx_q + 16'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        word_d  = word_q;
        addr_d  = addr_q;
        imem_d  = imem_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (in_byte == IMEM_TAG || in_byte == DMEM_TAG) begin
                        imem_d  = (in_byte == IMEM_TAG);
                        err_d   = 1'b0;
                        state_d = ST_LEN_HI;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    cnt_d[15:8] = in_byte;
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    cnt_d = len;
                    idx_d = '0;
                    if (len == 16'd0)
                        state_d = ST_DONE;
                    else if ({16'd0, len} > 32'(MEM_DEPTH))
                        state_d = ST_ERR;
                    else
                        state_d = ST_DAT_HI;
                end
            end
            ST_DAT_HI: begin
                if (accept) begin
                    hi_d    = in_byte;
                    state_d = ST_DAT_LO;
                end
            end
            ST_DAT_LO: begin
                // Address and word are latched here so they stay stable through WRITE and after it.
                if (accept) begin
                    word_d  = {hi_q, in_byte};
                    addr_d  = idx_q;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == cnt_q) ? ST_DONE : ST_DAT_HI;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign addr_ext           = addr_q;
    assign iram_in_ext        = word_q;
    assign data_in_ext        = word_q;
    assign mem_write_ins      = (state_q == ST_WRITE) &&  imem_q;
    assign mem_write_data_ext = (state_q == ST_WRITE) && !imem_q;
    assign start              = AUTO_START && (state_q == ST_DONE) && imem_q;
    assign busy               = (state_q != ST_IDLE);
    assign err                = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: frames driven byte by byte, writes captured by a monitor.
module tb_mem_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] addr_ext;
    logic [15:0] iram_in_ext;
    logic [15:0] data_in_ext;
    logic        mem_write_ins;
    logic        mem_write_data_ext;
    logic        start;
    logic        busy;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] wa[$];
    logic [15:0] wd[$];
    bit          wi[$];
    int          starts;
    int          ready_viol;
    int          both_viol;
    int          word_mismatch;

    mem_loader dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_byte            (in_byte),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .addr_ext           (addr_ext),
        .iram_in_ext        (iram_in_ext),
        .data_in_ext        (data_in_ext),
        .mem_write_ins      (mem_write_ins),
        .mem_write_data_ext (mem_write_data_ext),
        .start              (start),
        .busy               (busy),
        .err                (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled on the falling edge, half a cycle away from state changes.
    always @(negedge clk) begin
        if (mem_write_ins || mem_write_data_ext) begin
            wa.push_back(addr_ext);
            wd.push_back(iram_in_ext);
            wi.push_back(mem_write_ins);
            if (in_ready) ready_viol++;
            if (iram_in_ext !== data_in_ext) word_mismatch++;
        end
        if (mem_write_ins && mem_write_data_ext) both_viol++;
        if (start) starts++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        wi.delete();
        starts        = 0;
        ready_viol    = 0;
        both_viol     = 0;
        word_mismatch = 0;
    endtask

    // Called at a falling edge; returns at the falling edge after the byte is taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit taken;
        repeat (gap) @(negedge clk);
        in_byte  = b;
        in_valid = 1'b1;
        taken    = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (in_ready) begin
                taken = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!taken) check("handshake_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (!busy) begin
                idle = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!idle) check("idle_timeout", 32'd0, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_byte  = 8'h00;
        in_valid = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);

        check("rst_addr",   32'(addr_ext), 32'h0);
        check("rst_iram",   32'(iram_in_ext), 32'h0);
        check("rst_dmem",   32'(data_in_ext), 32'h0);
        check("rst_strobe", 32'({mem_write_ins, mem_write_data_ext}), 32'h0);
        check("rst_start",  32'(start), 32'h0);
        check("rst_busy",   32'(busy), 32'h0);
        check("rst_err",    32'(err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'h1);

        // Two-word instruction load with auto start.
        clear_mon();
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'hAB, 0); send_byte(8'hCD, 0);
        wait_idle();
        check("imem_nwr",    32'(wa.size()), 32'd2);
        check("imem_a0",     32'(wa[0]), 32'h0);
        check("imem_d0",     32'(wd[0]), 32'h1234);
        check("imem_sel0",   32'(wi[0]), 32'h1);
        check("imem_a1",     32'(wa[1]), 32'h1);
        check("imem_d1",     32'(wd[1]), 32'hABCD);
        check("imem_start",  32'(starts), 32'd1);
        check("hold_addr",   32'(addr_ext), 32'h1);
        check("hold_word",   32'(data_in_ext), 32'hABCD);

        // Single-word data load, never starts.
        clear_mon();
        send_byte(8'h5A, 0); send_byte(8'h00, 1); send_byte(8'h01, 0);
        send_byte(8'hBE, 2); send_byte(8'hEF, 0);
        wait_idle();
        check("dmem_nwr",   32'(wa.size()), 32'd1);
        check("dmem_sel",   32'(wi[0]), 32'h0);
        check("dmem_a0",    32'(wa[0]), 32'h0);
        check("dmem_d0",    32'(wd[0]), 32'hBEEF);
        check("dmem_start", 32'(starts), 32'd0);

        // Count 513 exceeds the memory.
        clear_mon();
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h01, 0);
        wait_idle();
        check("ovf_nwr",   32'(wa.size()), 32'd0);
        check("ovf_err",   32'(err), 32'h1);
        check("ovf_busy",  32'(busy), 32'h0);
        check("ovf_start", 32'(starts), 32'd0);

        // Bad tag, then an empty instruction frame.
        clear_mon();
        send_byte(8'h77, 0);
        check("badtag_err",  32'(err), 32'h1);
        check("badtag_busy", 32'(busy), 32'h0);
        send_byte(8'hA5, 0);
        check("tag_clears_err", 32'(err), 32'h0);
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        wait_idle();
        check("zero_nwr",   32'(wa.size()), 32'd0);
        check("zero_start", 32'(starts), 32'd1);

        // Full-depth load with random gaps.
        clear_mon();
        send_byte(8'hA5, 0); send_byte(8'h02, 1); send_byte(8'h00, 0);
        for (int i = 0; i < 512; i++) begin
            logic [15:0] w;
            w = 16'(i * 257 + 7);
            send_byte(w[15:8], $urandom_range(0, 2));
            send_byte(w[7:0],  $urandom_range(0, 2));
        end
        wait_idle();
        check("full_nwr", 32'(wa.size()), 32'd512);
        begin
            int bad_a, bad_d;
            bad_a = 0;
            bad_d = 0;
            for (int i = 0; i < wa.size(); i++) begin
                if (wa[i] !== 16'(i)) bad_a++;
                if (wd[i] !== 16'(i * 257 + 7)) bad_d++;
            end
            check("full_addr_order", 32'(bad_a), 32'd0);
            check("full_data",       32'(bad_d), 32'd0);
        end
        check("full_last_addr",    32'(addr_ext), 32'd511);
        check("write_ready_low",   32'(ready_viol), 32'd0);
        check("both_strobes",      32'(both_viol), 32'd0);
        check("word_ports_equal",  32'(word_mismatch), 32'd0);
        check("full_start",        32'(starts), 32'd1);

        // Reset in the middle of a frame.
        clear_mon();
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_addr",   32'(addr_ext), 32'h0);
        check("mrst_word",   32'({iram_in_ext, data_in_ext}), 32'h0);
        check("mrst_strobe", 32'({mem_write_ins, mem_write_data_ext, start}), 32'h0);
        check("mrst_busy",   32'(busy), 32'h0);
        check("mrst_err",    32'(err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (3) @(negedge clk);
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
        send_byte(8'hCA, 0); send_byte(8'hFE, 0);
        wait_idle();
        check("post_nwr",   32'(wa.size()), 32'd1);
        check("post_a0",    32'(wa[0]), 32'h0);
        check("post_d0",    32'(wd[0]), 32'hCAFE);
        check("post_sel",   32'(wi[0]), 32'h1);
        check("post_start", 32'(starts), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 512, giving the memory depth in words and the maximum legal word count.
REQ-002 SHALL have parameter IMEM_TAG, default 8'hA5, the header byte that selects the instruction memory.
REQ-003 SHALL have parameter DMEM_TAG, default 8'h5A, the header byte that selects the data memory.
REQ-004 SHALL have parameter AUTO_START, default 1, which enables the start pulse after an instruction load.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have ports for the incoming byte stream: in_byte (input, 8, byte data), in_valid (input, 1, byte offered) and in_ready (output, 1, byte accepted when in_valid=1 and in_ready=1 on the same edge).
REQ-008 SHALL have output addr_ext, 16 bits: the write address, zero-extended word index.
REQ-009 SHALL have outputs iram_in_ext and data_in_ext, 16 bits each, both carrying the same assembled write word.
REQ-010 SHALL have outputs mem_write_ins and mem_write_data_ext, 1 bit each: one-cycle write strobes for the instruction and data memories respectively.
REQ-011 SHALL have output start, 1 bit: a one-cycle pulse that launches the processor.
REQ-012 SHALL have outputs busy (1 bit, a frame is in progress) and err (1 bit, sticky error flag).

Function
REQ-013 SHALL accept frames made of a tag byte, then a count high byte and a count low byte, then count words, each sent high byte first.
REQ-014 SHALL implement the states IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, DONE and ERR.
REQ-015 In IDLE, a byte equal to IMEM_TAG or DMEM_TAG SHALL latch the target, clear err and move to LEN_HI; any other byte SHALL be consumed, set err and leave the block in IDLE.
REQ-016 LEN_HI and LEN_LO SHALL capture the 16-bit count; after LEN_LO, count=0 goes to DONE, count>MEM_DEPTH goes to ERR, and any other count goes to DAT_HI with the word index at 0.
REQ-017 DAT_HI SHALL capture bits [15:8] and DAT_LO SHALL capture bits [7:0] of the word, then move to WRITE.
REQ-018 WRITE SHALL last exactly one cycle, assert only the selected strobe with the current addr_ext and word, then increment the index.
REQ-019 After WRITE, the block SHALL go to DONE if the index equals count, otherwise to DAT_HI.
REQ-020 in_ready SHALL be 1 only in IDLE, LEN_HI, LEN_LO, DAT_HI and DAT_LO.
REQ-021 Bytes arriving while in_ready=0 SHALL be held off by the sender and never dropped.
REQ-022 DONE SHALL last one cycle and return to IDLE.
REQ-023 When AUTO_START=1 and the target is the instruction memory, DONE SHALL pulse start for exactly that cycle; a data-memory load SHALL never pulse start.
REQ-024 ERR SHALL last one cycle, set err, issue no write strobe and return to IDLE.
REQ-025 Both write strobes SHALL never be high in the same cycle.
REQ-026 Gaps in in_valid SHALL stall the frame indefinitely with no timeout.
REQ-027 The maximum legal count SHALL be MEM_DEPTH, with the last address MEM_DEPTH-1; the word index SHALL never wrap.
REQ-028 busy SHALL be 1 in every state except IDLE.
REQ-029 addr_ext and the word outputs SHALL hold their last values outside WRITE.

Reset
REQ-030 Assertion of rst_n=0 SHALL asynchronously force IDLE, with the index, count, addr_ext, iram_in_ext and data_in_ext at 0 and mem_write_ins, mem_write_data_ext, start, busy and err at 0.
REQ-031 A reset in the middle of a frame SHALL abandon the frame with no further strobes; the next frame SHALL start cleanly with its tag byte.

Structure
REQ-032 The tag constants, the state encoding and the MEM_DEPTH default SHALL live in a shared package, loader_pkg.
REQ-033 The design SHALL be a single module with no sub-modules, and the FSM and datapath SHALL be registered.

Verification
REQ-034 Stream A5 00 02 12 34 AB CD -> mem_write_ins pulses at addr 0 with 0x1234 and at addr 1 with 0xABCD, then start pulses once in DONE.
REQ-035 Stream 5A 00 01 BE EF -> one mem_write_data_ext pulse at addr 0 with 0xBEEF, with start remaining 0.
REQ-036 Stream A5 02 01 -> count 513 goes to ERR, err=1, there are no strobes, and the block returns to IDLE.
REQ-037 Stream 77 then A5 00 00 -> err=1 after the 0x77 byte, err clears on the A5 tag, the count of 0 produces no writes and start pulses.
REQ-038 Count 512 with random in_valid gaps -> 512 writes at addresses 0..511 in order, in_ready=0 in every WRITE cycle, and no byte is lost.
REQ-039 rst_n asserted after the first data word -> all outputs are 0 at once, and a following A5 00 01 frame writes addr 0 correctly.
